shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
- Consumes the team's ripple-carry adder stage: one WIDTH-bit add per clock, no parallel multiplier array.
- Single start/done handshake.
- Used wherever area matters more than latency.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- a  in  WIDTH  multiplicand; sampled on the accepting edge.
- b  in  WIDTH  multiplier; sampled on the accepting edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset: rst high at a rising edge forces the following on that edge, overriding all other inputs:
  - state = IDLE;
  - accumulator, multiplier shift register and counter cleared;
  - busy = 0, done = 0, product = 0.
- Reset mid-operation aborts the operation. No done is produced and product is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start = 1:
  - mcand <= a; acc_hi <= 0; acc_lo <= b; cnt <= 0.
- RUN, on each edge:
  - If acc_lo[0] = 1: {c, sum} = acc_hi + mcand via the WIDTH-bit adder, Cin = 0. Otherwise {c, sum} = {0, acc_hi}.
  - {acc_hi, acc_lo} <= {c, sum, acc_lo[WIDTH-1:1]}, i.e. a logical right shift with the carry entering the MSB.
  - cnt <= cnt + 1. On the edge where cnt = WIDTH-1, go to DONE and load product <= final {acc_hi, acc_lo}.
- DONE: done = 1 for exactly one cycle, then unconditionally IDLE on the next edge.
- Latency: start high in cycle 0 -> busy high in cycles 1..WIDTH+1 -> done and product valid in cycle WIDTH+1.
- Back-to-back: start in cycle WIDTH+2 (first IDLE cycle) is accepted. Throughput is one product per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored. a and b are don't-care outside the accepting edge.
- Arithmetic: unsigned only. The carry out of the adder is never lost; the product is exact for all inputs, e.g. 15 x 15 = 225 at WIDTH=4.
- Counter width: $clog2(WIDTH)+1 bits.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_ADD_MULT_ZERO_SKIP_EN.
- Defined: if a == 0 or b == 0 on the accepting edge, go IDLE -> DONE directly and load product <= 0. done is high in cycle 1, busy is high in cycle 1 only, and RUN is never entered.
- Undefined: zero operands take the full WIDTH+1 latency, with product = 0. No extra logic is compiled.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - default width constant MULT_WIDTH_DEF = 4.
- One natural sub-module: adder_nbit, a combinational parameterized WIDTH-bit ripple adder with ports (a, b, cin, sum, cout). It is instantiated once, in the RUN datapath.

Test Plan:
- WIDTH=4, a=3, b=5, start in cycle 0 -> done pulse in cycle 5 only, product = 15; busy high cycles 1..5.
- a=15, b=15 -> product = 225 (8'hE1), which checks the carry path. Exhaustive sweep of all 256 pairs against a*b.
- a=0, b=9:
  - macro undefined -> done in cycle 5, product = 0;
  - macro defined -> done in cycle 1, product = 0.
- Start a=2, b=3. Re-pulse start with a=7, b=7 in cycle 2 -> ignored; product = 6 in cycle 5.
- Start a=9, b=9, then assert rst in cycle 3 -> cycle 4: busy = 0, product = 0, no done pulse; a new start a=4, b=4 afterwards yields 16.
- Back-to-back: a=6, b=7 (product 42 in cycle 5), then start in cycle 6 with a=10, b=11 -> product 110 in cycle 11; product holds 42 during cycles 5..10.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier.
//   ST_IDLE / ST_RUN / ST_DONE : FSM state encoding
//   MULT_WIDTH_DEF             : default operand width
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MULT_WIDTH_DEF = 4;

endpackage

// File: rtl/adder_nbit.sv
// Combinational WIDTH-bit ripple-carry adder.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   sum   out WIDTH  a + b + cin, low WIDTH bits
//   cout  out 1      carry out
module adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One WIDTH-bit add per clock through adder_nbit.
// Ports:
//   clk      in  1        system clock, rising edge
//   rst      in  1        synchronous active-high reset
//   start    in  1        request pulse, accepted only in IDLE
//   a, b     in  WIDTH    multiplicand / multiplier, sampled on accept
//   busy     out 1        state != IDLE
//   done     out 1        one-cycle pulse, product valid
//   product  out 2*WIDTH  result, held until the next accepted start
// Build option: SHIFT_ADD_MULT_ZERO_SKIP_EN -- a zero operand jumps straight
// from IDLE to DONE with product = 0.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | WIDTH add/shift iterations
// DONE    | done pulse, product valid
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] shifted;

    adder_nbit #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry enters the MSB of the right shift, so no product bit is lost.
    always_comb begin
        if (acc_lo_q[0]) begin
            shifted = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
        end else begin
            shifted = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                    end
`endif
                end
            end
            ST_RUN: begin
                {acc_hi_d, acc_lo_d} = shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = ST_DONE;
                    product_d = shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_vec = 0;
    int n_err = 0;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] xa, input logic [W-1:0] xb);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
        if (xa == 0 || xb == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Called at a negedge in cycle 0; returns at the negedge of cycle 1.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(negedge clk);
        start = 1'b0;
        a     = 'x;
        b     = 'x;
    endtask

    // Waits for done (bounded), checks latency and product, optionally that
    // product holds a previous value and busy stays high while waiting.
    // Returns at the negedge of the first IDLE cycle after done.
    task automatic wait_done(input string name, input int lat0, input int lat_exp,
                             input int prod_exp, input bit hold_en, input int hold_val,
                             input bit full);
        int lat;
        bit bad_busy;
        bit bad_hold;
        lat      = lat0;
        bad_busy = 1'b0;
        bad_hold = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) bad_busy = 1'b1;
            if (hold_en && product != hold_val[2*W-1:0]) bad_hold = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (full) begin
            chk({name, " latency"}, lat, lat_exp);
            chk({name, " busy_while_running"}, int'(bad_busy), 0);
            chk({name, " busy_in_done"}, int'(busy), 1);
            if (hold_en) chk({name, " product_hold"}, int'(bad_hold), 0);
        end
        chk({name, " product"}, int'(product), prod_exp);
        @(negedge clk);
        if (full) begin
            chk({name, " done_one_cycle"}, int'(done), 0);
            chk({name, " busy_after"}, int'(busy), 0);
        end
    endtask

    initial begin
        int seen_done;

        vecs[0] = '{4'd3,  4'd5,  8'd15};
        vecs[1] = '{4'd15, 4'd15, 8'd225};
        vecs[2] = '{4'd0,  4'd9,  8'd0};
        vecs[3] = '{4'd9,  4'd0,  8'd0};
        vecs[4] = '{4'd1,  4'd1,  8'd1};
        vecs[5] = '{4'd15, 4'd1,  8'd15};
        vecs[6] = '{4'd8,  4'd2,  8'd16};
        vecs[7] = '{4'd12, 4'd13, 8'd156};
        vecs[8] = '{4'd7,  4'd9,  8'd63};
        vecs[9] = '{4'd1,  4'd15, 8'd15};

        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset product", int'(product), 0);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].va, vecs[i].vb);
            wait_done($sformatf("vec%0d %0dx%0d", i, vecs[i].va, vecs[i].vb), 1,
                      exp_lat(vecs[i].va, vecs[i].vb), int'(vecs[i].exp), 1'b0, 0, 1'b1);
        end

        // start while busy is ignored
        start_op(4'd2, 4'd3);
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_restart", 3, W + 1, 6, 1'b0, 0, 1'b1);

        // reset mid-operation aborts without a done pulse
        start_op(4'd9, 4'd9);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort product", int'(product), 0);
        chk("abort done", int'(done), 0);
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort no_done", seen_done, 0);
        start_op(4'd4, 4'd4);
        wait_done("after_abort 4x4", 1, W + 1, 16, 1'b0, 0, 1'b1);

        // back-to-back with product hold
        start_op(4'd6, 4'd7);
        wait_done("b2b first 6x7", 1, W + 1, 42, 1'b0, 0, 1'b1);
        start_op(4'd10, 4'd11);
        wait_done("b2b second 10x11", 1, W + 1, 110, 1'b1, 42, 1'b1);

        // exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                start_op(i[W-1:0], j[W-1:0]);
                wait_done($sformatf("sweep %0dx%0d", i, j), 1, exp_lat(i[W-1:0], j[W-1:0]),
                          i * j, 1'b0, 0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
